// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register file write port
// between ALU and load writeback, with a pending-write scoreboard.
module rf_wb_arbiter #(
  parameter logic PRIO_INIT = 1'b0,
  parameter logic SB_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_rd,
  input  logic [4:0]  q_rs,
  input  logic [4:0]  q_rt,
  output logic        stall,
  output logic [31:0] busy_mask,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);

  logic        prio;
  logic [31:0] busy_q;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [31:0] busy_d;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  // grant: single requester wins outright, contention goes to prio holder
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      a_ready = a_valid & (!b_valid | !prio);
      b_ready = b_valid & (!a_valid | prio);
    end
  end

  // winner's write bundle feeding the output stage
  always_comb begin
    sel_rd   = b_rd;
    sel_data = b_data;
    if (a_ready) begin
      sel_rd   = a_rd;
      sel_data = a_data;
    end
  end

  // priority pointer moves to the loser after every grant
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= PRIO_INIT;
    end else if (a_ready) begin
      prio <= 1'b1;
    end else if (b_ready) begin
      prio <= 1'b0;
    end
  end

  // registered write port; x0 writes are swallowed here
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (a_ready | b_ready) begin
      rf_we    <= (sel_rd != 5'd0);
      rf_rd    <= sel_rd;
      rf_wdata <= sel_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // scoreboard next state: commit clears, reserve sets, set wins
  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (rsv_valid) begin
      set_vec[rsv_rd] = 1'b1;
    end
    if (rf_we) begin
      clr_vec[rf_rd] = 1'b1;
    end
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // hazard query against current mask, no same-cycle commit bypass
  always_comb begin
    busy_mask = SB_EN ? busy_q : 32'd0;
    stall     = busy_mask[q_rs] | busy_mask[q_rt];
  end

endmodule
